// File: rtl/gf22_sram_pkg.sv
// Shared constants, bank-index helper and posted-write buffer types for the
// banked GF22 SRAM wrapper.
package gf22_sram_pkg;
    localparam int MACRO_WIDTH     = 64;
    localparam int MACRO_DEPTH_MAX = 8192;
    localparam int ADDR_MAX_W      = 32;

    typedef logic [MACRO_WIDTH-1:0] macro_word_t;

    // Write-buffer tag; addresses are held zero-extended to ADDR_MAX_W.
    typedef struct packed {
        logic                  valid;
        logic [ADDR_MAX_W-1:0] addr;
    } wb_tag_t;

    // One macro-wide slice of the buffered write payload.
    typedef struct packed {
        macro_word_t data;
        macro_word_t mask;
    } wb_lane_t;

    function automatic logic [ADDR_MAX_W-1:0] bank_index(input logic [ADDR_MAX_W-1:0] addr,
                                                          input int bank_awidth);
        return addr >> bank_awidth;
    endfunction
endpackage

// File: rtl/GF22_SRAM_SP_1024x64.sv
// Behavioural model of the GF22 1024x64 single-port macro: active-low chip,
// global-write and per-bit write enables, registered read data.
module GF22_SRAM_SP_1024x64 (
    input  logic        CLK,
    input  logic        CEN,
    input  logic        GWEN,
    input  logic [63:0] WEN,
    input  logic [9:0]  A,
    input  logic [63:0] D,
    output logic [63:0] Q
);
    logic [63:0] mem [1024];

    always_ff @(posedge CLK) begin
        if (!CEN) begin
            if (GWEN) Q <= mem[A];
            else      mem[A] <= (mem[A] & WEN) | (D & ~WEN);
        end
    end
endmodule

// File: rtl/GF22_SRAM_SP_4096x64.sv
// Behavioural model of the GF22 4096x64 single-port macro: active-low chip,
// global-write and per-bit write enables, registered read data.
module GF22_SRAM_SP_4096x64 (
    input  logic        CLK,
    input  logic        CEN,
    input  logic        GWEN,
    input  logic [63:0] WEN,
    input  logic [11:0] A,
    input  logic [63:0] D,
    output logic [63:0] Q
);
    logic [63:0] mem [4096];

    always_ff @(posedge CLK) begin
        if (!CEN) begin
            if (GWEN) Q <= mem[A];
            else      mem[A] <= (mem[A] & WEN) | (D & ~WEN);
        end
    end
endmodule

// File: rtl/GF22_SRAM_SP_8192x64.sv
// Behavioural model of the GF22 8192x64 single-port macro: active-low chip,
// global-write and per-bit write enables, registered read data.
module GF22_SRAM_SP_8192x64 (
    input  logic        CLK,
    input  logic        CEN,
    input  logic        GWEN,
    input  logic [63:0] WEN,
    input  logic [12:0] A,
    input  logic [63:0] D,
    output logic [63:0] Q
);
    logic [63:0] mem [8192];

    always_ff @(posedge CLK) begin
        if (!CEN) begin
            if (GWEN) Q <= mem[A];
            else      mem[A] <= (mem[A] & WEN) | (D & ~WEN);
        end
    end
endmodule

// File: rtl/gf22_sram_wbuf.sv
// One-entry posted-write buffer: parks writes that collide with a read, retires
// them when their bank is free, and captures forwarding data for reads that hit.
module gf22_sram_wbuf
    import gf22_sram_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 18,
    parameter int BANK_AWIDTH = 13
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_req,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DATA_WIDTH-1:0] wr_mask,
    input  logic                  rd_req,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rdy,
    output logic                  mw_en,
    output logic [ADDR_WIDTH-1:0] mw_addr,
    output logic [DATA_WIDTH-1:0] mw_data,
    output logic [DATA_WIDTH-1:0] mw_mask,
    output logic                  fwd_hit_p1,
    output logic [DATA_WIDTH-1:0] fwd_data_p1,
    output logic [DATA_WIDTH-1:0] fwd_mask_p1
);
    localparam int NH = DATA_WIDTH / MACRO_WIDTH;

    wb_tag_t               wb_tag;
    wb_lane_t [NH-1:0]     wb_lane;
    logic [ADDR_MAX_W-1:0] wr_addr_x;
    logic [ADDR_MAX_W-1:0] rd_addr_x;
    logic [DATA_WIDTH-1:0] wb_data;
    logic [DATA_WIDTH-1:0] wb_mask;
    logic                  accept;
    logic                  park;
    logic                  retire;
    logic                  wb_hit;

    assign wr_addr_x = ADDR_MAX_W'(wr_addr);
    assign rd_addr_x = ADDR_MAX_W'(rd_addr);

    // Ready comes straight from the buffer flop, so no input reaches RDY0 combinationally.
    assign rdy    = !wb_tag.valid;
    assign accept = wr_req && rdy;
    assign park   = accept && rd_req &&
                    (bank_index(wr_addr_x, BANK_AWIDTH) == bank_index(rd_addr_x, BANK_AWIDTH));
    assign retire = wb_tag.valid &&
                    !(rd_req && (bank_index(wb_tag.addr, BANK_AWIDTH) == bank_index(rd_addr_x, BANK_AWIDTH)));
    assign wb_hit = wb_tag.valid && rd_req && (wb_tag.addr == rd_addr_x);

    always_comb begin
        wb_data = '0;
        wb_mask = '0;
        for (int h = 0; h < NH; h++) begin
            wb_data[h*MACRO_WIDTH +: MACRO_WIDTH] = wb_lane[h].data;
            wb_mask[h*MACRO_WIDTH +: MACRO_WIDTH] = wb_lane[h].mask;
        end
    end

    // Retire and direct write are mutually exclusive: new writes only arrive with the buffer empty.
    assign mw_en   = retire || (accept && !park);
    assign mw_addr = wb_tag.valid ? ADDR_WIDTH'(wb_tag.addr) : wr_addr;
    assign mw_data = wb_tag.valid ? wb_data : wr_data;
    assign mw_mask = wb_tag.valid ? wb_mask : wr_mask;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_tag     <= '0;
            fwd_hit_p1 <= 1'b0;
        end else begin
            fwd_hit_p1 <= wb_hit;
            if (park) begin
                wb_tag.valid <= 1'b1;
                wb_tag.addr  <= wr_addr_x;
            end else if (retire) begin
                wb_tag.valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (park) begin
            for (int h = 0; h < NH; h++) begin
                wb_lane[h].data <= wr_data[h*MACRO_WIDTH +: MACRO_WIDTH];
                wb_lane[h].mask <= wr_mask[h*MACRO_WIDTH +: MACRO_WIDTH];
            end
        end
        if (wb_hit) begin
            fwd_data_p1 <= wb_data;
            fwd_mask_p1 <= wb_mask;
        end
    end
endmodule

// File: rtl/gf22_sram_be_banked.sv
// Banked 1W/1R SRAM with bit write masks built from GF22 single-port macros;
// read wins bank collisions and the losing write is posted in gf22_sram_wbuf.
module gf22_sram_be_banked
    import gf22_sram_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 18,
    parameter int BANK_AWIDTH = 13
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic                  CE0,
    input  logic                  WE0,
    input  logic [ADDR_WIDTH-1:0] A0,
    input  logic [DATA_WIDTH-1:0] D0,
    input  logic [DATA_WIDTH-1:0] WEM0,
    output logic                  RDY0,
    input  logic                  CE1,
    input  logic [ADDR_WIDTH-1:0] A1,
    output logic [DATA_WIDTH-1:0] Q1,
    output logic                  QV1
);
    localparam int NH  = DATA_WIDTH / MACRO_WIDTH;
    localparam int NBW = ADDR_WIDTH - BANK_AWIDTH;
    localparam int NV  = 1 << NBW;
    // Smallest compiled macro that covers the bank depth; spare address bits are tied low.
    localparam int MACRO_AW = (BANK_AWIDTH <= 10) ? 10 :
                              (BANK_AWIDTH <= 12) ? 12 : $clog2(MACRO_DEPTH_MAX);

    function automatic logic [DATA_WIDTH-1:0] merge_masked(input logic [DATA_WIDTH-1:0] old_q,
                                                           input logic [DATA_WIDTH-1:0] new_d,
                                                           input logic [DATA_WIDTH-1:0] mask);
        return (old_q & ~mask) | (new_d & mask);
    endfunction

    logic                          mw_en;
    logic [ADDR_WIDTH-1:0]         mw_addr;
    logic [DATA_WIDTH-1:0]         mw_data;
    logic [DATA_WIDTH-1:0]         mw_mask;
    logic                          fwd_hit_p1;
    logic [DATA_WIDTH-1:0]         fwd_data_p1;
    logic [DATA_WIDTH-1:0]         fwd_mask_p1;
    logic [NBW-1:0]                rd_bank;
    logic [NBW-1:0]                mw_bank;
    logic [NBW-1:0]                rd_bank_p1;
    logic                          vld_p1;
    logic [NV-1:0][DATA_WIDTH-1:0] bank_q;
    logic [DATA_WIDTH-1:0]         sel_q;

    assign rd_bank = NBW'(bank_index(ADDR_MAX_W'(A1), BANK_AWIDTH));
    assign mw_bank = NBW'(bank_index(ADDR_MAX_W'(mw_addr), BANK_AWIDTH));

    gf22_sram_wbuf #(
        .DATA_WIDTH  (DATA_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .BANK_AWIDTH (BANK_AWIDTH)
    ) u_wbuf (
        .clk         (CLK),
        .rst_n       (RSTN),
        .wr_req      (CE0 && WE0),
        .wr_addr     (A0),
        .wr_data     (D0),
        .wr_mask     (WEM0),
        .rd_req      (CE1),
        .rd_addr     (A1),
        .rdy         (RDY0),
        .mw_en       (mw_en),
        .mw_addr     (mw_addr),
        .mw_data     (mw_data),
        .mw_mask     (mw_mask),
        .fwd_hit_p1  (fwd_hit_p1),
        .fwd_data_p1 (fwd_data_p1),
        .fwd_mask_p1 (fwd_mask_p1)
    );

    for (genvar b = 0; b < NV; b++) begin : g_bank
        logic                rd_sel;
        logic                wr_sel;
        logic                cen;
        logic                gwen;
        logic [MACRO_AW-1:0] maddr;

        assign rd_sel = CE1 && (rd_bank == NBW'(b));
        assign wr_sel = mw_en && (mw_bank == NBW'(b));
        assign cen    = !(rd_sel || wr_sel);
        // The write buffer never steers a write into the bank being read.
        assign gwen   = !wr_sel;
        assign maddr  = rd_sel ? MACRO_AW'(A1[BANK_AWIDTH-1:0]) : MACRO_AW'(mw_addr[BANK_AWIDTH-1:0]);

        for (genvar h = 0; h < NH; h++) begin : g_col
            if (MACRO_AW == 10) begin : g_1k
                GF22_SRAM_SP_1024x64 u_macro (
                    .CLK (CLK), .CEN (cen), .GWEN (gwen),
                    .WEN (~mw_mask[h*MACRO_WIDTH +: MACRO_WIDTH]), .A (maddr),
                    .D   (mw_data[h*MACRO_WIDTH +: MACRO_WIDTH]),
                    .Q   (bank_q[b][h*MACRO_WIDTH +: MACRO_WIDTH])
                );
            end else if (MACRO_AW == 12) begin : g_4k
                GF22_SRAM_SP_4096x64 u_macro (
                    .CLK (CLK), .CEN (cen), .GWEN (gwen),
                    .WEN (~mw_mask[h*MACRO_WIDTH +: MACRO_WIDTH]), .A (maddr),
                    .D   (mw_data[h*MACRO_WIDTH +: MACRO_WIDTH]),
                    .Q   (bank_q[b][h*MACRO_WIDTH +: MACRO_WIDTH])
                );
            end else begin : g_8k
                GF22_SRAM_SP_8192x64 u_macro (
                    .CLK (CLK), .CEN (cen), .GWEN (gwen),
                    .WEN (~mw_mask[h*MACRO_WIDTH +: MACRO_WIDTH]), .A (maddr),
                    .D   (mw_data[h*MACRO_WIDTH +: MACRO_WIDTH]),
                    .Q   (bank_q[b][h*MACRO_WIDTH +: MACRO_WIDTH])
                );
            end
        end
    end

    // p0 -> p1: read issue; macro data lands alongside the registered bank select.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            vld_p1     <= 1'b0;
            rd_bank_p1 <= '0;
        end else begin
            vld_p1 <= CE1;
            if (CE1) rd_bank_p1 <= rd_bank;
        end
    end

    assign sel_q = bank_q[rd_bank_p1];
    assign QV1   = vld_p1;
    assign Q1    = !vld_p1   ? '0 :
                   fwd_hit_p1 ? merge_masked(sel_q, fwd_data_p1, fwd_mask_p1) : sel_q;
endmodule

// File: tb/tb_gf22_sram_be_banked.sv
// Bench for gf22_sram_be_banked: directed collision, forwarding and reset cases
// plus random traffic against a word-level memory model; also a 128-bit build.
module tb_gf22_sram_be_banked;
    logic clk;
    logic rstn;

    logic         ce0, we0, ce1, rdy0, qv1;
    logic [17:0]  a0, a1;
    logic [63:0]  d0, wem0, q1;

    logic         w_ce0, w_we0, w_ce1, w_rdy0, w_qv1;
    logic [11:0]  w_a0, w_a1;
    logic [127:0] w_d0, w_wem0, w_q1;

    int n_checks = 0;
    int n_fail   = 0;

    gf22_sram_be_banked dut (
        .CLK (clk), .RSTN (rstn), .CE0 (ce0), .WE0 (we0), .A0 (a0), .D0 (d0),
        .WEM0 (wem0), .RDY0 (rdy0), .CE1 (ce1), .A1 (a1), .Q1 (q1), .QV1 (qv1)
    );

    gf22_sram_be_banked #(.DATA_WIDTH(128), .ADDR_WIDTH(12), .BANK_AWIDTH(10)) dut_w (
        .CLK (clk), .RSTN (rstn), .CE0 (w_ce0), .WE0 (w_we0), .A0 (w_a0), .D0 (w_d0),
        .WEM0 (w_wem0), .RDY0 (w_rdy0), .CE1 (w_ce1), .A1 (w_a1), .Q1 (w_q1), .QV1 (w_qv1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: committed words plus at most one posted write that is
    // already visible to reads but not yet committed (dropped on reset).
    logic [63:0] mem_m [int unsigned];
    bit          pend;
    int unsigned p_addr;
    logic [63:0] p_data, p_mask;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [63:0] m);
        return (old & ~m) | (d & m);
    endfunction

    function automatic logic [63:0] committed(input int unsigned a);
        return mem_m.exists(a) ? mem_m[a] : 64'h0;
    endfunction

    function automatic logic [63:0] model_read(input int unsigned a);
        logic [63:0] v;
        v = committed(a);
        if (pend && p_addr == a) v = merge(v, p_data, p_mask);
        return v;
    endfunction

    // One clock of the 64-bit DUT; called at a falling edge, returns at the next one.
    task automatic step(input bit c0, input bit w0, input int unsigned aw, input logic [63:0] dw,
                        input logic [63:0] mw, input bit c1, input int unsigned ar);
        bit          acc;
        bit          exp_qv;
        logic [63:0] exp_q;
        ce0 = c0; we0 = w0; a0 = aw[17:0]; d0 = dw; wem0 = mw; ce1 = c1; a1 = ar[17:0];
        acc    = c0 && w0 && !pend;
        exp_qv = c1;
        exp_q  = c1 ? model_read(ar) : 64'h0;
        if (pend && !(c1 && (ar >> 13) == (p_addr >> 13))) begin
            mem_m[p_addr] = merge(committed(p_addr), p_data, p_mask);
            pend = 1'b0;
        end
        if (acc) begin
            if (c1 && (ar >> 13) == (aw >> 13)) begin
                pend = 1'b1; p_addr = aw; p_data = dw; p_mask = mw;
            end else begin
                mem_m[aw] = merge(committed(aw), dw, mw);
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("qv1", 128'(qv1), 128'(exp_qv));
        chk("q1", 128'(q1), 128'(exp_q));
        chk("rdy0", 128'(rdy0), 128'(!pend));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 0, 64'h0, 64'h0, 1'b0, 0);
    endtask

    task automatic wstep(input bit c0, input logic [11:0] aw, input logic [127:0] dw,
                         input logic [127:0] mw, input bit c1, input logic [11:0] ar);
        w_ce0 = c0; w_we0 = c0; w_a0 = aw; w_d0 = dw; w_wem0 = mw; w_ce1 = c1; w_a1 = ar;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        ce0 = 1'b0; ce1 = 1'b0; w_ce0 = 1'b0; w_ce1 = 1'b0;
        rstn = 1'b0;
        #1;
        chk("rst_rdy0", 128'(rdy0), 128'(1'b1));
        chk("rst_qv1", 128'(qv1), 128'(1'b0));
        chk("rst_q1", 128'(q1), 128'h0);
        pend = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    int unsigned pool [14] = '{'h00005, 'h00006, 'h00100, 'h00200, 'h02000, 'h02010, 'h02020,
                               'h04000, 'h04001, 'h04002, 'h04003, 'h04004, 'h04005, 'h06000};
    logic [127:0] ww [4];

    initial begin
        logic [63:0]  rdata;
        logic [127:0] wd;
        pend = 1'b0;
        rstn = 1'b1;
        ce0 = 0; we0 = 0; a0 = '0; d0 = '0; wem0 = '0; ce1 = 0; a1 = '0;
        w_ce0 = 0; w_we0 = 0; w_a0 = '0; w_d0 = '0; w_wem0 = '0; w_ce1 = 0; w_a1 = '0;
        #1 rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("reset_rdy0", 128'(rdy0), 128'(1'b1));
        chk("reset_qv1", 128'(qv1), 128'(1'b0));
        chk("reset_q1", 128'(q1), 128'h0);
        chk("reset_w_rdy0", 128'(w_rdy0), 128'(1'b1));
        chk("reset_w_qv1", 128'(w_qv1), 128'(1'b0));
        rstn = 1'b1;

        for (int i = 0; i < 14; i++) step(1'b1, 1'b1, pool[i], {$urandom, $urandom}, '1, 1'b0, 0);
        step(1'b1, 1'b1, 'h02000, 64'h0, '1, 1'b0, 0);
        step(1'b1, 1'b1, 'h00005, '1, '1, 1'b0, 0);
        step(1'b1, 1'b1, 'h00100, 64'h0, '1, 1'b0, 0);

        // Same-bank write/read collision: read served, write parked then retired.
        rdata = committed('h02010);
        step(1'b1, 1'b1, 'h02000, {16{4'hA}}, '1, 1'b1, 'h02010);
        chk("t1_read_old", 128'(q1), 128'(rdata));
        chk("t1_rdy_low", 128'(rdy0), 128'(1'b0));
        idle();
        chk("t1_rdy_back", 128'(rdy0), 128'(1'b1));
        idle();
        step(1'b0, 1'b0, 0, 64'h0, 64'h0, 1'b1, 'h02000);
        chk("t1_readback", 128'(q1), 128'({16{4'hA}}));

        // Partial-mask write forwarded from the buffer.
        step(1'b1, 1'b1, 'h00005, 64'hDEADBEEF12345678, 64'h00000000FFFFFFFF, 1'b1, 'h00006);
        step(1'b0, 1'b0, 0, 64'h0, 64'h0, 1'b1, 'h00005);
        chk("t2_forward", 128'(q1), 128'(64'hFFFFFFFF12345678));
        idle();
        step(1'b0, 1'b0, 0, 64'h0, 64'h0, 1'b1, 'h00005);
        chk("t2_committed", 128'(q1), 128'(64'hFFFFFFFF12345678));

        // Same-cycle write and read of one address returns the old word.
        step(1'b1, 1'b1, 'h00100, 64'h0123456789ABCDEF, '1, 1'b1, 'h00100);
        chk("t3_old", 128'(q1), 128'h0);
        idle();
        idle();
        step(1'b0, 1'b0, 0, 64'h0, 64'h0, 1'b1, 'h00100);
        chk("t3_new", 128'(q1), 128'(64'h0123456789ABCDEF));

        // Reads to the parked bank hold RDY0 low; a refused write must not land.
        rdata = committed('h06000);
        step(1'b1, 1'b1, 'h04000, 64'h5555AAAA5555AAAA, '1, 1'b1, 'h04001);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, 'h06000, 64'hBAD0BAD0BAD0BAD0, '1, 1'b1, 'h04001 + i);
            chk("t4_rdy_hold", 128'(rdy0), 128'(1'b0));
        end
        idle();
        chk("t4_retired", 128'(rdy0), 128'(1'b1));
        step(1'b0, 1'b0, 0, 64'h0, 64'h0, 1'b1, 'h06000);
        chk("t4_refused", 128'(q1), 128'(rdata));
        step(1'b0, 1'b0, 0, 64'h0, 64'h0, 1'b1, 'h04000);
        chk("t4_written", 128'(q1), 128'(64'h5555AAAA5555AAAA));

        // Reset while a write is parked discards it.
        rdata = committed('h02020);
        step(1'b1, 1'b1, 'h02020, 64'hCAFEF00DCAFEF00D, '1, 1'b1, 'h02000);
        do_reset();
        idle();
        step(1'b0, 1'b0, 0, 64'h0, 64'h0, 1'b1, 'h02020);
        chk("t5_old_kept", 128'(q1), 128'(rdata));

        for (int n = 0; n < 400; n++) begin
            int          iw, ir;
            logic [63:0] m;
            iw = int'($urandom_range(13, 0));
            ir = int'($urandom_range(13, 0));
            m  = (($urandom % 3) == 0) ? 64'hFFFFFFFFFFFFFFFF : {$urandom, $urandom};
            step(($urandom % 4) != 0, ($urandom % 4) != 0, pool[iw], {$urandom, $urandom}, m,
                 ($urandom % 2) != 0, pool[ir]);
        end
        ce0 = 1'b0; ce1 = 1'b0;

        // 128-bit build: four banks, two macros side by side.
        for (int i = 0; i < 4; i++) begin
            ww[i] = {$urandom, $urandom, $urandom, $urandom};
            wstep(1'b1, 12'(i * 'h400), ww[i], '1, 1'b0, 12'h0);
            chk("w_rdy", 128'(w_rdy0), 128'(1'b1));
        end
        for (int i = 0; i < 4; i++) begin
            wstep(1'b0, 12'h0, '0, '0, 1'b1, 12'(i * 'h400));
            chk("w_qv", 128'(w_qv1), 128'(1'b1));
            chk("w_readback", w_q1, ww[i]);
        end
        wd = {$urandom, $urandom, $urandom, $urandom};
        wstep(1'b1, 12'h400, wd, {{64{1'b1}}, 64'h0}, 1'b0, 12'h0);
        wstep(1'b0, 12'h0, '0, '0, 1'b1, 12'h400);
        chk("w_upper_mask", w_q1, {wd[127:64], ww[1][63:0]});
        wd = {$urandom, $urandom, $urandom, $urandom};
        wstep(1'b1, 12'h001, wd, '1, 1'b1, 12'h000);
        chk("w_conflict_read", w_q1, ww[0]);
        chk("w_conflict_rdy", 128'(w_rdy0), 128'(1'b0));
        wstep(1'b0, 12'h0, '0, '0, 1'b0, 12'h0);
        chk("w_retire_rdy", 128'(w_rdy0), 128'(1'b1));
        wstep(1'b0, 12'h0, '0, '0, 1'b1, 12'h001);
        chk("w_conflict_data", w_q1, wd);
        wstep(1'b0, 12'h0, '0, '0, 1'b0, 12'h0);
        chk("w_idle_q", w_q1, 128'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/gf22_sram_be_banked.md
# gf22_sram_be_banked

Parametrised 1-write/1-read banked SRAM built from GF22 single-port macros with bit-level write masks, for accelerator private local memories and LLC data arrays. Unlike fixed-size generated wrappers, width and depth are parameters. Read/write collisions on the same bank are resolved in hardware: the read wins, and the write is parked in a one-entry posted-write buffer that is retired later and forwarded to reads. The write port carries a ready signal; the read port carries a valid signal.

## Interface
- DATA_WIDTH, 64: word width; multiple of 64 (macro width); NH = DATA_WIDTH/64 macros side by side per bank.
- ADDR_WIDTH, 18: word address width.
- BANK_AWIDTH, 13: macro address width (depth 2^BANK_AWIDTH, ≤ 8192); NV = 2^(ADDR_WIDTH-BANK_AWIDTH) banks.
- CLK  in  1  clock, all state on rising edge.
- RSTN  in  1  reset, asynchronous, active-low.
- CE0  in  1  write request; acts only together with WE0.
- WE0  in  1  write enable; write accepted iff CE0 & WE0 & RDY0.
- A0  in  ADDR_WIDTH  write address.
- D0  in  DATA_WIDTH  write data.
- WEM0  in  DATA_WIDTH  bit write mask, 1 = bit written.
- RDY0  out  1  write port ready.
- CE1  in  1  read request; always accepted.
- A1  in  ADDR_WIDTH  read address.
- Q1  out  DATA_WIDTH  read data.
- QV1  out  1  Q1 valid.

## Operation
- Bank index = A[ADDR_WIDTH-1:BANK_AWIDTH]; macro address = A[BANK_AWIDTH-1:0].
- Per-bank priority each cycle: read (CE1) > buffered write > new write.
- Write buffer (WB): {valid, addr, data, mask}. RDY0 = !WB.valid (registered; no combinational path from inputs).
- Accepted write, bank ≠ read bank (or no read): written to the bank this cycle.
- Accepted write, bank = read bank: parked in WB; WB.valid = 1 next cycle.
- WB retirement: in any cycle where WB.valid and (!CE1 or read bank ≠ WB bank), WB is written to its bank and WB.valid clears next cycle. No new write can arrive while WB.valid, so a retirement never collides with a new write.
- Visibility: a write is visible to reads issued in cycles strictly after acceptance. A same-cycle read of the same address returns the old data.
- Forwarding: a read issued while WB.valid with A1 == WB.addr returns Q1 = (bank_q & ~WB.mask) | (WB.data & WB.mask). The hit, mask and data are captured at read issue. This also applies when WB retires in the same cycle.
- Q1 is forced to 0 when QV1 = 0.
- Reset (any time): WB.valid = 0 and a parked write is discarded; RDY0 = 1, QV1 = 0, Q1 = 0. Macro contents are unaffected.

## Timing
- Read latency 1: CE1 at edge t → QV1 = 1 and Q1 valid in cycle t+1. Back-to-back reads run at full rate.
- Write throughput: 1/cycle with no conflicts. After a conflict, RDY0 is low for ≥1 cycle, staying low until WB retires; a stream of reads to the WB bank holds RDY0 low indefinitely. This is by design.
- Retire latency is at least 1 cycle after parking.

## Structure
- Package gf22_sram_pkg holds:
  - MACRO_WIDTH = 64
  - MACRO_DEPTH_MAX = 8192
  - the bank-index function
  - the WB struct type
- Sub-module gf22_sram_wbuf: WB register, RDY0, retire decision, address compare, forwarding capture.
- The top level holds per-bank steering, macro instances (GF22_SRAM_SP_<depth>x64) and the output mux/merge registered by bank select.

## Test plan
- Simultaneous write A0=0x02000, D0=0xAA..AA, full mask, and read A1=0x02010 (same bank 1) → read served, RDY0 = 0 next cycle, WB retires cycle after; read of 0x02000 at t+3 returns 0xAA..AA.
- Read 0x00005 while WB holds 0x00005 with mask 0x00000000FFFFFFFF, data 0x...12345678, old word 0xFFFF..FF → Q1 = 0xFFFFFFFF12345678.
- Same-cycle write and read to 0x00100, old value 0x0 → Q1 = 0x0; read at t+3 returns new data.
- Park write, then drive reads to the same bank for 5 cycles → RDY0 low for 5 cycles, retire on first non-conflicting cycle.
- Park write, assert RSTN low mid-hold → RDY0 = 1, QV1 = 0, Q1 = 0; later read shows old data.
- DATA_WIDTH = 128, ADDR_WIDTH = 12, BANK_AWIDTH = 10: writes to 0x000/0x400/0x800/0xC00 and readback, plus masked upper-half write → only bits 127:64 change.
